// File: rtl/count_sequence_checker.sv
// Checker for a free-running counter bus: locks onto a +STEP sequence, then
// flags, counts and resynchronises on every out-of-sequence sample.
module count_sequence_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP       = 1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic             locked,
  output logic             err,
  output logic             wrap,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACQUIRE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam int unsigned MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
  localparam int unsigned EW = (ERR_LIMIT > 1) ? $clog2(ERR_LIMIT + 1) : 1;

  localparam logic [WIDTH-1:0] STEP_W      = WIDTH'(STEP);
  localparam logic [MW-1:0]    LOCK_LAST   = MW'(LOCK_COUNT - 1);
  localparam logic [EW-1:0]    ERR_LAST    = EW'(ERR_LIMIT - 1);

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] prev, prev_n;
  logic [MW-1:0]    match_cnt, match_cnt_n;
  logic [EW-1:0]    consec_err, consec_err_n;
  logic             err_n, wrap_n;
  logic [CNT_W-1:0] err_count_n;
  logic [WIDTH-1:0] expected_n;
  logic [WIDTH-1:0] next_val;
  logic             match;

  assign next_val = data_in + STEP_W;
  assign match    = (data_in == prev + STEP_W);
  assign locked   = (state == S_LOCKED);

  always_comb begin
    state_n      = state;
    prev_n       = prev;
    match_cnt_n  = match_cnt;
    consec_err_n = consec_err;
    err_n        = 1'b0;
    wrap_n       = 1'b0;
    err_count_n  = err_count;
    expected_n   = expected;

    if (clear) begin
      // clear wins over a same-cycle sample, which is simply dropped
      state_n      = S_IDLE;
      prev_n       = '0;
      match_cnt_n  = '0;
      consec_err_n = '0;
      err_count_n  = '0;
      expected_n   = '0;
    end else if (en) begin
      prev_n = data_in;
      case (state)
        S_IDLE: begin
          state_n     = S_ACQUIRE;
          match_cnt_n = '0;
          expected_n  = '0;
        end
        S_ACQUIRE: begin
          if (match) begin
            if (match_cnt == LOCK_LAST) begin
              state_n      = S_LOCKED;
              consec_err_n = '0;
              expected_n   = next_val;
            end else begin
              match_cnt_n = match_cnt + MW'(1);
            end
          end else begin
            match_cnt_n = '0;
          end
        end
        S_LOCKED: begin
          expected_n = next_val;
          if (match) begin
            consec_err_n = '0;
            wrap_n       = (data_in < prev);
          end else begin
            err_n = 1'b1;
            if (err_count != '1) begin
              err_count_n = err_count + CNT_W'(1);
            end
            if (consec_err == ERR_LAST) begin
              state_n      = S_ACQUIRE;
              match_cnt_n  = '0;
              consec_err_n = '0;
              expected_n   = '0;
            end else begin
              consec_err_n = consec_err + EW'(1);
            end
          end
        end
        default: begin
          state_n    = S_IDLE;
          expected_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      prev       <= '0;
      match_cnt  <= '0;
      consec_err <= '0;
      err        <= 1'b0;
      wrap       <= 1'b0;
      err_count  <= '0;
      expected   <= '0;
    end else begin
      state      <= state_n;
      prev       <= prev_n;
      match_cnt  <= match_cnt_n;
      consec_err <= consec_err_n;
      err        <= err_n;
      wrap       <= wrap_n;
      err_count  <= err_count_n;
      expected   <= expected_n;
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Randomised and directed bench for count_sequence_checker against a
// behavioural model of the lock/error rules.
module tb_count_sequence_checker;

  localparam int WIDTH      = 8;
  localparam int STEP       = 1;
  localparam int LOCK_COUNT = 4;
  localparam int ERR_LIMIT  = 3;
  localparam int CNT_W      = 4;
  localparam int MOD        = 1 << WIDTH;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             locked, err, wrap;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] expected;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 acquiring, 2 locked
  int m_mode = 0, m_prev = 0, m_run = 0, m_bad = 0, m_cnt = 0, m_exp = 0;
  int m_err = 0, m_wrap = 0;
  int last_d = 0;

  count_sequence_checker #(
    .WIDTH(WIDTH), .STEP(STEP), .LOCK_COUNT(LOCK_COUNT),
    .ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .clear(clear), .data_in(data_in),
    .locked(locked), .err(err), .wrap(wrap), .err_count(err_count),
    .expected(expected)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_bad = 0; m_cnt = 0;
    m_exp = 0; m_err = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit e, input bit c, input int d);
    bit hit;
    m_err = 0; m_wrap = 0;
    if (c) begin
      m_mode = 0; m_cnt = 0; m_run = 0; m_bad = 0; m_prev = 0;
    end else if (e) begin
      hit = (d == (m_prev + STEP) % MOD);
      if (m_mode == 0) begin
        m_mode = 1; m_run = 0;
      end else if (m_mode == 1) begin
        m_run = hit ? m_run + 1 : 0;
        if (m_run >= LOCK_COUNT) begin m_mode = 2; m_bad = 0; end
      end else begin
        if (hit) begin
          m_bad = 0;
          m_wrap = (d < m_prev) ? 1 : 0;
        end else begin
          m_err = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
          m_bad++;
          if (m_bad >= ERR_LIMIT) begin m_mode = 1; m_run = 0; end
        end
      end
      m_prev = d;
    end
    m_exp = (m_mode == 2) ? (m_prev + STEP) % MOD : 0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".locked"},    32'(locked),    (m_mode == 2) ? 32'd1 : 32'd0);
    check({tag, ".err"},       32'(err),       32'(m_err));
    check({tag, ".wrap"},      32'(wrap),      32'(m_wrap));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
    check({tag, ".expected"},  32'(expected),  32'(m_exp));
  endtask

  task automatic step(input bit e, input bit c, input int d, input string tag);
    @(negedge clock);
    en = e; clear = c; data_in = d[WIDTH-1:0];
    if (e) last_d = d % MOD;
    @(posedge clock);
    model_edge(e, c, d % MOD);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int v;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clock);
    reset = 1'b1;

    // lock onto 0..4
    for (int i = 0; i < 5; i++) step(1, 0, i, "t1");
    check("t1_locked", 32'(locked), 32'd1);
    check("t1_expected", 32'(expected), 32'd5);
    check("t1_errcnt", 32'(err_count), 32'd0);

    // run up to the wrap
    for (int i = 5; i < 256; i++) step(1, 0, i, "t2run");
    step(1, 0, 0, "t2wrap");
    check("t2_wrap_pulse", 32'(wrap), 32'd1);
    check("t2_no_err", 32'(err), 32'd0);
    step(1, 0, 1, "t2after");
    check("t2_wrap_clear", 32'(wrap), 32'd0);

    // single glitch with resync
    for (int i = 2; i <= 16; i++) step(1, 0, i, "t3run");
    step(1, 0, 8'h20, "t3bad");
    check("t3_err", 32'(err), 32'd1);
    check("t3_cnt", 32'(err_count), 32'd1);
    step(1, 0, 8'h21, "t3resync");
    check("t3_no_err", 32'(err), 32'd0);
    check("t3_locked", 32'(locked), 32'd1);
    step(1, 0, 8'h22, "t3run2");

    // three consecutive errors drop lock
    step(1, 0, 8'h05, "t4bad1");
    step(1, 0, 8'h50, "t4bad2");
    check("t4_still_locked", 32'(locked), 32'd1);
    step(1, 0, 8'hA0, "t4bad3");
    check("t4_err3", 32'(err), 32'd1);
    check("t4_cnt", 32'(err_count), 32'd4);
    check("t4_unlocked", 32'(locked), 32'd0);
    for (int i = 1; i <= 3; i++) step(1, 0, 8'hA0 + i, "t4relock");
    check("t4_not_yet", 32'(locked), 32'd0);
    step(1, 0, 8'hA4, "t4relock");
    check("t4_relocked", 32'(locked), 32'd1);

    // gated samples with data held
    for (int i = 5; i < 10; i++) begin
      step(1, 0, 8'hA0 + i, "t5en");
      step(0, 0, 8'hA0 + i, "t5hold");
      check("t5_no_err", 32'(err), 32'd0);
    end
    check("t5_locked", 32'(locked), 32'd1);

    // clear beats a mismatching sample
    step(1, 1, 8'h77, "t6clear");
    check("t6_err", 32'(err), 32'd0);
    check("t6_cnt", 32'(err_count), 32'd0);
    check("t6_locked", 32'(locked), 32'd0);

    // saturation of err_count
    for (int i = 0; i < 5; i++) step(1, 0, i, "sat_lock");
    v = 4;
    for (int i = 0; i < 20; i++) begin
      v = (v + 8'h40) % MOD;
      step(1, 0, v, "sat_bad");
      check("sat_err_pulse", 32'(err), 32'd1);
      v = (v + 1) % MOD;
      step(1, 0, v, "sat_good");
    end
    check("sat_cnt", 32'(err_count), 32'(CNT_MAX));

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit e, c;
      int d;
      e = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 88) d = (last_d + STEP) % MOD;
      else d = $urandom_range(0, MOD - 1);
      step(e, c, d, "rand");
    end

    // asynchronous reset while locked
    for (int i = 0; i < 6; i++) step(1, 0, 8'h30 + i, "rst_lock");
    check("rst_pre_locked", 32'(locked), 32'd1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(negedge clock);
    reset = 1'b1;
    step(1, 0, 8'h10, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
